// File: rtl/rob_pkg.sv
// rob_pkg: shared types and constants for the reorder buffer / retire stage.
//   XLEN            datapath width of result values.
//   ROB_DEPTH_DEF   default number of ROB entries (power of two, >= 2).
//   rob_tag_t       tag type for the default depth.
//   rob_entry_t     per-entry state: valid, complete, has_dest, dest_idx, value.
package rob_pkg;

  localparam int XLEN          = 32;
  localparam int ROB_DEPTH_DEF = 16;
  localparam int ROB_TAG_W     = $clog2(ROB_DEPTH_DEF);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic            has_dest;
    logic [4:0]      dest_idx;
    logic [XLEN-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer with a single-wide retire stage that
// drives the architectural regfile write port.
//
// Ports:
//   clock, reset_n                 clock (posedge) and async active-low reset
//   dispatch_valid/has_dest/dest_idx   allocate one entry at the tail
//   dispatch_ready, dispatch_tag   ROB not full; tag given to the dispatch
//   cdb_valid/cdb_tag/cdb_data     result broadcast; marks an entry complete
//   flush                          squash everything at the next edge
//   retire_valid                   head entry retires this cycle
//   write_en/write_idx/write_data  regfile write port (x0 never written)
//   rob_empty, rob_full            occupancy flags
//   retire_count (optional)        retirements since reset/flush; present
//                                  only when ROB_RETIRE_COUNT_EN is defined
module rob_retire
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         dispatch_valid,
  input  logic                         dispatch_has_dest,
  input  logic [4:0]                   dispatch_dest_idx,
  output logic                         dispatch_ready,
  output logic [$clog2(ROB_DEPTH)-1:0] dispatch_tag,
  input  logic                         cdb_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0] cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  input  logic                         flush,
  output logic                         retire_valid,
  output logic                         write_en,
  output logic [4:0]                   write_idx,
  output logic [XLEN-1:0]              write_data,
  output logic                         rob_empty,
  output logic                         rob_full
`ifdef ROB_RETIRE_COUNT_EN
  ,
  output logic [31:0]                  retire_count
`endif
);

  localparam int             TAG_W    = $clog2(ROB_DEPTH);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

  rob_entry_t       entries [ROB_DEPTH];
  rob_entry_t       head_entry;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic [TAG_W:0]   count_nxt;
  logic             do_dispatch;
  logic             do_cdb;

  assign head_entry     = entries[head];
  assign rob_empty      = (count == '0);
  assign rob_full       = (count == FULL_CNT);
  // Readiness comes from registered occupancy only, so a retire in the same
  // cycle never opens a slot for dispatch.
  assign dispatch_ready = !rob_full;
  assign dispatch_tag   = tail;

  assign retire_valid = head_entry.valid && head_entry.complete;
  assign write_en     = retire_valid && head_entry.has_dest && (head_entry.dest_idx != 5'd0);
  assign write_idx    = retire_valid ? head_entry.dest_idx : 5'd0;
  assign write_data   = retire_valid ? head_entry.value : '0;

  // Flush takes priority over new allocation and result capture.
  assign do_dispatch = dispatch_valid && dispatch_ready && !flush;
  assign do_cdb      = cdb_valid && entries[cdb_tag].valid && !flush;

  always_comb begin
    count_nxt = count;
    case ({do_dispatch, retire_valid})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // ---- entry storage ----
  // A dispatching entry is never the CDB target (not yet valid) and never the
  // retiring head (tail == head only when empty), so the writes below never
  // collide on live state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i].valid    <= 1'b0;
        entries[i].complete <= 1'b0;
      end
    end else begin
      if (retire_valid) entries[head].valid <= 1'b0;
      if (do_cdb) begin
        entries[cdb_tag].complete <= 1'b1;
        entries[cdb_tag].value    <= cdb_data;
      end
      if (do_dispatch) begin
        entries[tail].valid    <= 1'b1;
        entries[tail].complete <= 1'b0;
        entries[tail].has_dest <= dispatch_has_dest;
        entries[tail].dest_idx <= dispatch_dest_idx;
      end
    end
  end

  // ---- pointers and occupancy ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire_valid) head <= head + 1'b1;
      if (do_dispatch)  tail <= tail + 1'b1;
      count <= count_nxt;
    end
  end

`ifdef ROB_RETIRE_COUNT_EN
  // ---- retirement counter ----
  // A retire in the flush cycle is the first retirement of the new epoch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retire_count <= '0;
    end else if (flush) begin
      retire_count <= {31'd0, retire_valid};
    end else if (retire_valid) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed scenarios plus randomized traffic for rob_retire,
// checked every cycle against a queue-based model of program order.
// Define ROB_RETIRE_COUNT_EN to also check the optional retire_count port.
module tb_rob_retire;
  import rob_pkg::*;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic        dispatch_has_dest = 1'b0;
  logic [4:0]  dispatch_dest_idx = '0;
  logic        dispatch_ready;
  logic [3:0]  dispatch_tag;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        flush = 1'b0;
  logic        retire_valid;
  logic        write_en;
  logic [4:0]  write_idx;
  logic [31:0] write_data;
  logic        rob_empty;
  logic        rob_full;
`ifdef ROB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  rob_retire #(.ROB_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .dispatch_valid(dispatch_valid),
    .dispatch_has_dest(dispatch_has_dest),
    .dispatch_dest_idx(dispatch_dest_idx),
    .dispatch_ready(dispatch_ready),
    .dispatch_tag(dispatch_tag),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .flush(flush),
    .retire_valid(retire_valid),
    .write_en(write_en),
    .write_idx(write_idx),
    .write_data(write_data),
    .rob_empty(rob_empty),
    .rob_full(rob_full)
`ifdef ROB_RETIRE_COUNT_EN
    ,
    .retire_count(retire_count)
`endif
  );

  always #5 clock = ~clock;

  // Model: in-flight instructions in program order, oldest first.
  typedef struct {
    int          tag;
    bit          has_dest;
    int          idx;
    bit          done;
    logic [31:0] val;
  } m_ent_t;

  m_ent_t      q[$];
  int          m_tail;
  int unsigned m_rcnt;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic bit m_retire();
    return (q.size() > 0) && q[0].done;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit r;
    bit wen;
    r   = m_retire();
    wen = r && q[0].has_dest && (q[0].idx != 0);
    chk("empty", 32'(rob_empty), 32'(q.size() == 0));
    chk("full", 32'(rob_full), 32'(q.size() == DEPTH));
    chk("ready", 32'(dispatch_ready), 32'(q.size() != DEPTH));
    chk("dtag", 32'(dispatch_tag), 32'(m_tail));
    chk("retire", 32'(retire_valid), 32'(r));
    chk("wen", 32'(write_en), 32'(wen));
    chk("widx", 32'(write_idx), r ? 32'(q[0].idx) : 32'd0);
    chk("wdata", write_data, r ? q[0].val : 32'd0);
`ifdef ROB_RETIRE_COUNT_EN
    chk("rcnt", retire_count, m_rcnt);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_rcnt = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit r;
    bit was_full;
    m_ent_t e;
    r        = m_retire();
    was_full = (q.size() == DEPTH);
    if (flush) begin
      q.delete();
      m_tail = 0;
      m_rcnt = r ? 1 : 0;
      return;
    end
    if (cdb_valid) begin
      foreach (q[i]) begin
        if (q[i].tag == int'(cdb_tag)) begin
          q[i].done = 1'b1;
          q[i].val  = cdb_data;
        end
      end
    end
    if (r) begin
      void'(q.pop_front());
      m_rcnt++;
    end
    if (dispatch_valid && !was_full) begin
      e.tag      = m_tail;
      e.has_dest = dispatch_has_dest;
      e.idx      = int'(dispatch_dest_idx);
      e.done     = 1'b0;
      e.val      = '0;
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  // Called at a negedge: check, drive, take one edge, return at next negedge.
  task automatic cyc(input bit dv, input bit hd, input logic [4:0] di,
                     input bit cv, input logic [3:0] ct, input logic [31:0] cd,
                     input bit fl);
    check_model();
    dispatch_valid    = dv;
    dispatch_has_dest = hd;
    dispatch_dest_idx = di;
    cdb_valid         = cv;
    cdb_tag           = ct;
    cdb_data          = cd;
    flush             = fl;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ready"}, 32'(dispatch_ready), 32'd1);
    chk({pfx, "_dtag"}, 32'(dispatch_tag), 32'd0);
    chk({pfx, "_retire"}, 32'(retire_valid), 32'd0);
    chk({pfx, "_wen"}, 32'(write_en), 32'd0);
    chk({pfx, "_widx"}, 32'(write_idx), 32'd0);
    chk({pfx, "_wdata"}, write_data, 32'd0);
    chk({pfx, "_empty"}, 32'(rob_empty), 32'd1);
    chk({pfx, "_full"}, 32'(rob_full), 32'd0);
  endtask

  initial begin
    logic [3:0] t;
    int         pick;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk_reset_outputs("rst");
    reset_n = 1'b1;

    // Two results arrive out of order; retirement stays in program order.
    cyc(1, 1, 5'd5, 0, 4'd0, 32'h0, 0);
    cyc(1, 1, 5'd6, 0, 4'd0, 32'h0, 0);
    cyc(1, 1, 5'd0, 0, 4'd0, 32'h0, 0);
    chk("s1_dtag", 32'(dispatch_tag), 32'd3);
    cyc(0, 0, 5'd0, 1, 4'd1, 32'hB, 0);
    chk("s1_noret", 32'(retire_valid), 32'd0);
    cyc(0, 0, 5'd0, 1, 4'd0, 32'hA, 0);
    chk("s1_wen0", 32'(write_en), 32'd1);
    chk("s1_idx0", 32'(write_idx), 32'd5);
    chk("s1_data0", write_data, 32'hA);
    idle();
    chk("s1_idx1", 32'(write_idx), 32'd6);
    chk("s1_data1", write_data, 32'hB);
    cyc(0, 0, 5'd0, 1, 4'd2, 32'h7, 0);
    chk("s1_ret2", 32'(retire_valid), 32'd1);
    chk("s1_wen2", 32'(write_en), 32'd0);
    idle();
    chk("s1_empty", 32'(rob_empty), 32'd1);

    // Fill to capacity; extra dispatch is dropped.
    cyc(0, 0, 5'd0, 0, 4'd0, 32'h0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 5'(i + 1), 0, 4'd0, 32'h0, 0);
    chk("full_flag", 32'(rob_full), 32'd1);
    chk("full_ready", 32'(dispatch_ready), 32'd0);
    chk("full_dtag", 32'(dispatch_tag), 32'd0);
    cyc(1, 1, 5'd9, 0, 4'd0, 32'h0, 0);
    chk("full_17_dtag", 32'(dispatch_tag), 32'd0);
    chk("full_17_full", 32'(rob_full), 32'd1);
    cyc(0, 0, 5'd0, 1, 4'd0, 32'h55, 0);
    chk("full_ret", 32'(retire_valid), 32'd1);
    cyc(1, 1, 5'd9, 0, 4'd0, 32'h0, 0);
    chk("full_after_full", 32'(rob_full), 32'd0);
    chk("full_after_dtag", 32'(dispatch_tag), 32'd0);
    chk("full_after_empty", 32'(rob_empty), 32'd0);

    // Walk the pointers to 14, then allocate across the wrap point.
    cyc(0, 0, 5'd0, 0, 4'd0, 32'h0, 1);
    for (int i = 0; i < 14; i++) cyc(1, 1, 5'd1, 0, 4'd0, 32'h0, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 5'd0, 1, 4'(i), 32'(i), 0);
    idle();
    idle();
    chk("wrap_empty", 32'(rob_empty), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_dtag", 32'(dispatch_tag), 32'((14 + i) % 16));
      cyc(1, 1, 5'(((14 + i) % 16) + 1), 0, 4'd0, 32'h0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      t = 4'((14 + i) % 16);
      cyc(0, 0, 5'd0, 1, t, 32'h100 + 32'(i), 0);
      chk("wrap_ret", 32'(retire_valid), 32'd1);
      chk("wrap_idx", 32'(write_idx), 32'(t) + 32'd1);
      chk("wrap_data", write_data, 32'h100 + 32'(i));
    end

    // Flush with five live entries, a dispatch and a CDB hit in the same cycle.
    idle();
    cyc(1, 1, 5'd3, 0, 4'd0, 32'h0, 0);
    chk("fl_pre_empty", 32'(rob_empty), 32'd0);
    cyc(1, 1, 5'd4, 1, 4'd2, 32'hDEAD, 1);
    chk("fl_empty", 32'(rob_empty), 32'd1);
    chk("fl_dtag", 32'(dispatch_tag), 32'd0);
    chk("fl_wen", 32'(write_en), 32'd0);
    chk("fl_ret", 32'(retire_valid), 32'd0);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int k = 0; k < 2000; k++) begin
      if (k == 1000) begin
        #2;
        reset_n = 1'b0;
        dispatch_valid = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk_reset_outputs("async");
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
      end else begin
        if ((q.size() > 0) && ($urandom_range(0, 4) != 0)) begin
          pick = $urandom_range(0, q.size() - 1);
          t = 4'(q[pick].tag);
        end else begin
          t = 4'($urandom_range(0, 15));
        end
        cyc($urandom_range(0, 9) < 7, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1) == 1, t, 32'($urandom), $urandom_range(0, 99) < 2);
      end
    end
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
